layer_stream_sequencer: RTL and testbench
=========================================

# layer_stream_sequencer

Inter-layer sequencer between a fully-parallel neuron layer and the next layer's serial input.
- Captures the NN neuron results of a layer in one cycle when the layer reports completion.
- Replays them one word per accepted cycle onto the next layer's shared `x_in`/`x_valid` broadcast, honouring a downstream stall.
- Flags results lost while a replay is still in progress, and counts completed frames.

## Interface
Parameters
- `NN`, default 10: neurons in the upstream layer; words per frame; must be ≥ 1.
- `dataWidth`, default 16: width of one neuron output.

Ports
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `o_valid` in NN: per-neuron done strobes from the upstream layer.
- `x_in` in NN*dataWidth: upstream results; neuron k occupies bits `[k*dataWidth +: dataWidth]`.
- `out_ready` in 1: downstream may take a word this cycle.
- `clr_err` in 1: clears `ovf_err` and `skew_err`.
- `x_out` out dataWidth: serialized word to the next layer.
- `x_valid` out 1: `x_out` is valid for exactly this cycle.
- `x_last` out 1: with `x_valid`, marks word NN-1.
- `busy` out 1: a frame is held or being replayed.
- `ovf_err` out 1: sticky; a frame arrived while busy.
- `skew_err` out 1: sticky; `o_valid` was not all-ones when `o_valid[0]` was high.
- `frame_cnt` out 16: frames fully replayed; wraps at 16 bits.

## Operation
- Reset (`rst`=0 at an edge): state IDLE, index = 0, buffer contents don't-care. Every output resets to 0.
- The index counter is max(1, $clog2(NN)) bits wide.
- **IDLE**
  - At an edge with `o_valid[0]`=1: copy all of `x_in` into the NN-word buffer, set index = 0, go to SHIFT.
  - `busy` is 1 from the next cycle onward.
- **SHIFT**
  - At each edge with `out_ready`=1: register `x_out` = buf[index] and `x_valid` = 1, set `x_last` = (index == NN-1), then index++.
  - At an edge with `out_ready`=0: register `x_valid` = 0 and `x_last` = 0; `x_out` holds its value.
  - When word NN-1 is emitted: same edge increments `frame_cnt`, returns to IDLE and clears `busy`.
- **Overflow**
  - `o_valid[0]`=1 at an edge while in SHIFT: the incoming frame is dropped and `ovf_err` is set.
  - This includes the edge that emits the last word.
  - The buffer being replayed is never disturbed.
- **Skew**
  - At any edge with `o_valid[0]`=1 and `o_valid` ≠ all-ones: set `skew_err`.
  - The capture still happens if in IDLE.
- **Error clear**
  - `clr_err`=1 clears both sticky flags.
  - If a set condition and `clr_err` occur on the same edge, set wins.
- **Reset mid-frame**: the frame is abandoned. No `x_valid` in the cycle after reset, counters cleared.
- NN=1: a frame is a single word with `x_last`=1.

## Timing
- Capture edge E0 → first `x_valid` registered at E1 at the earliest (1-cycle latency), with `out_ready` high continuously.
- Minimum frame duration is NN cycles of `x_valid`. They are contiguous when `out_ready` stays high; stalls insert gaps without reordering.
- Earliest next capture is the edge after the last-word edge: IDLE re-entered at En, capture at En+1.
- `x_valid`, `x_last` and `x_out` are registered outputs with no combinational path from inputs.
- `busy`, `frame_cnt` and the error flags update on the same edge as their causing event.

## Test plan
Bench parameters: NN=10, dataWidth=16.
- **Basic frame**: word k = 16'h0100+k, `o_valid`=10'h3FF for one cycle, `out_ready`=1 → `x_out` = 0x0100..0x0109 on 10 consecutive `x_valid` cycles starting 1 cycle after capture; `x_last` only on 0x0109; `frame_cnt`=1; `busy` low after.
- **Stall**: `out_ready` toggles 1,0,0,1,... → all 10 words in order; no `x_valid` during stalled cycles; `x_out` stable across stalls.
- **Overflow**: second `o_valid`=3FF 4 cycles into replay → first frame is output intact; `ovf_err`=1; `frame_cnt`=1. Then `clr_err` pulse → `ovf_err`=0.
- **Skew**: `o_valid`=10'h1FF with bit0=1 → `skew_err`=1 and the frame is still replayed. `clr_err` asserted on the same edge as a new skew → `skew_err` stays 1.
- **Back-to-back**: second frame presented on the edge after the last word → accepted; no `ovf_err`; 20 words total; `frame_cnt`=2.
- **Reset mid-replay** (`rst`=0 after word 3): all outputs are 0 next cycle; `frame_cnt`=0. A subsequent frame replays from word 0.

Source files
------------

// File: rtl/layer_stream_sequencer.sv
// layer_stream_sequencer: captures a parallel layer's results in one cycle and replays them as a serial word stream.
module layer_stream_sequencer #(
  parameter int NN = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           o_valid,
  input  logic [NN*dataWidth-1:0] x_in,
  input  logic                    out_ready,
  input  logic                    clr_err,
  output logic [dataWidth-1:0]    x_out,
  output logic                    x_valid,
  output logic                    x_last,
  output logic                    busy,
  output logic                    ovf_err,
  output logic                    skew_err,
  output logic [15:0]             frame_cnt
);
  localparam int IW = NN > 1 ? $clog2(NN) : 1;
  localparam logic [0:0] IDLE = 1'b0, SHIFT = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] idx;
  logic [dataWidth-1:0] mem [NN];
  logic cap, last, emit;
  assign cap = o_valid[0] && state == IDLE;
  assign emit = state == SHIFT && out_ready;
  assign last = idx == IW'(NN - 1);
  assign busy = state == SHIFT;
  // Buffer is only written from IDLE, so a frame under replay is never disturbed.
  always_ff @(posedge clk) begin
    if (cap)
      for (int k = 0; k < NN; k++) mem[k] <= x_in[k*dataWidth +: dataWidth];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      x_out <= '0;
      x_valid <= 1'b0;
      x_last <= 1'b0;
      ovf_err <= 1'b0;
      skew_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      ovf_err <= (o_valid[0] && state == SHIFT) || (ovf_err && !clr_err);
      skew_err <= (o_valid[0] && o_valid != '1) || (skew_err && !clr_err);
      x_valid <= emit;
      x_last <= emit && last;
      if (cap) begin
        state <= SHIFT;
        idx <= '0;
      end else if (emit) begin
        x_out <= mem[idx];
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          state <= IDLE;
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_layer_stream_sequencer.sv
// tb_layer_stream_sequencer: scoreboard bench; stimulus queues expected words, a negedge monitor checks them.
module tb_layer_stream_sequencer;
  localparam int NN = 10, DW = 16;
  logic clk = 1'b0, rst = 1'b0, out_ready = 1'b1, clr_err = 1'b0;
  logic [NN-1:0] o_valid = '0;
  logic [NN*DW-1:0] x_in = '0;
  logic [DW-1:0] x_out;
  logic x_valid, x_last, busy, ovf_err, skew_err;
  logic [15:0] frame_cnt;
  logic [DW:0] q[$];
  logic [DW-1:0] last_out = '0;
  int vecs = 0, fails = 0, popped = 0;

  layer_stream_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .o_valid(o_valid), .x_in(x_in), .out_ready(out_ready),
    .clr_err(clr_err), .x_out(x_out), .x_valid(x_valid), .x_last(x_last), .busy(busy),
    .ovf_err(ovf_err), .skew_err(skew_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    vecs++;
    if (x_valid) begin
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word got %h last %b, none expected", x_out, x_last);
      end else begin
        logic [DW:0] e;
        e = q.pop_front();
        if ({x_last, x_out} !== e) begin
          fails++;
          $display("FAIL word got last=%b data=%h, expected last=%b data=%h", x_last, x_out, e[DW], e[DW-1:0]);
        end
      end
      last_out = x_out;
      popped++;
    end else if (x_out !== last_out || x_last !== 1'b0) begin
      fails++;
      $display("FAIL hold got data=%h last=%b, expected data=%h last=0", x_out, x_last, last_out);
    end
  end

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic present(input logic [15:0] base, input logic [NN-1:0] ov, input bit accept);
    for (int k = 0; k < NN; k++) begin
      x_in[k*DW +: DW] = base + 16'(k);
      if (accept) q.push_back({k == NN - 1, base + 16'(k)});
    end
    o_valid = ov;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    q.delete();
    last_out = '0;
    o_valid = '0;
    clr_err = 1'b0;
    out_ready = 1'b1;
    cyc;
    chk("rst_x_valid", 32'(x_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", {ovf_err, skew_err}, 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b1;
    popped = 0;
  endtask

  task automatic drain;
    int n = 0;
    while ((q.size() > 0 || busy) && n < 200) begin
      cyc;
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc;
    // Basic frame and latency
    do_reset;
    present(16'h0100, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    chk("basic_busy_after_capture", 32'(busy), 1);
    chk("basic_no_valid_at_capture", 32'(x_valid), 0);
    cyc;
    chk("basic_first_valid", {x_valid, x_out}, {1'b1, 16'h0100});
    repeat (9) cyc;
    chk("basic_last_word", {x_valid, x_last, x_out}, {2'b11, 16'h0109});
    chk("basic_busy_done", 32'(busy), 0);
    chk("basic_frame_cnt", 32'(frame_cnt), 1);
    cyc;
    chk("basic_words", popped, 10);
    chk("basic_idle_valid", 32'(x_valid), 0);
    // Stall pattern 1,0,0,...
    do_reset;
    present(16'h1A00, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    begin
      int emitted = 0, i = 0;
      while (emitted < NN && i < 40) begin
        out_ready = (i % 3) == 0;
        cyc;
        chk("stall_valid", 32'(x_valid), 32'(out_ready && emitted < NN));
        if (out_ready) emitted++;
        i++;
      end
      chk("stall_all_emitted", emitted, NN);
    end
    out_ready = 1'b1;
    drain;
    chk("stall_frame_cnt", 32'(frame_cnt), 1);
    // Overflow mid-replay, then on the last-word edge
    do_reset;
    present(16'h0200, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    repeat (3) cyc;
    present(16'h0300, 10'h3FF, 0);
    cyc;
    o_valid = '0;
    chk("ovf_set", 32'(ovf_err), 1);
    drain;
    chk("ovf_frame_cnt", 32'(frame_cnt), 1);
    chk("ovf_words", popped, 10);
    present(16'h0400, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    clr_err = 1'b1;
    cyc;
    clr_err = 1'b0;
    chk("ovf_cleared", 32'(ovf_err), 0);
    repeat (8) cyc;
    present(16'h0500, 10'h3FF, 0);
    cyc;
    o_valid = '0;
    chk("ovf_last_edge_set", 32'(ovf_err), 1);
    chk("ovf_last_edge_x_last", {x_valid, x_last, x_out}, {2'b11, 16'h0409});
    chk("ovf_last_edge_cnt", 32'(frame_cnt), 2);
    cyc;
    chk("ovf_dropped_busy", 32'(busy), 0);
    // Skew
    do_reset;
    present(16'h0600, 10'h1FF, 1);
    cyc;
    o_valid = '0;
    chk("skew_set", 32'(skew_err), 1);
    chk("skew_captured", 32'(busy), 1);
    drain;
    chk("skew_frame_cnt", 32'(frame_cnt), 1);
    present(16'h0700, 10'h1FF, 1);
    clr_err = 1'b1;
    cyc;
    o_valid = '0;
    clr_err = 1'b0;
    chk("skew_set_wins", 32'(skew_err), 1);
    drain;
    clr_err = 1'b1;
    cyc;
    clr_err = 1'b0;
    chk("skew_cleared", {ovf_err, skew_err}, 0);
    chk("skew_frame_cnt2", 32'(frame_cnt), 2);
    // Back-to-back
    do_reset;
    present(16'h0800, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    repeat (10) cyc;
    chk("b2b_idle", 32'(busy), 0);
    present(16'h0900, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    chk("b2b_accepted", 32'(busy), 1);
    chk("b2b_no_ovf", 32'(ovf_err), 0);
    drain;
    chk("b2b_frame_cnt", 32'(frame_cnt), 2);
    chk("b2b_words", popped, 20);
    // Reset mid-replay
    do_reset;
    present(16'h0A00, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    repeat (3) cyc;
    chk("midrst_words_before", popped, 3);
    do_reset;
    chk("midrst_x_out", {x_last, x_out}, 0);
    present(16'h0B00, 10'h3FF, 1);
    cyc;
    o_valid = '0;
    drain;
    chk("midrst_frame_cnt", 32'(frame_cnt), 1);
    chk("midrst_words", popped, 10);
    cyc;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
